// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for a simple accumulator-less
// register machine. Walks T0..T6 per instruction, decodes the opcode held in
// the datapath's IR, and emits the register-load, bus-drive, register-select,
// memory and ALU control strobes. All outputs are Moore-decoded from the
// current step and the opcode. The one exception is PCin in T6 of a branch,
// which follows CON directly.

module control_sequencer #(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [DATA_W-1:0] i_ir,
   input  logic              i_con,
   // register-load enables
   output logic              o_pcin,
   output logic              o_mdrin,
   output logic              o_marin,
   output logic              o_irin,
   output logic              o_yin,
   output logic              o_zin,
   output logic              o_conin,
   output logic              o_rin,
   // bus-drive enables
   output logic              o_pcout,
   output logic              o_mdrout,
   output logic              o_zloout,
   output logic              o_cout,
   output logic              o_rout,
   output logic              o_baout,
   // register-field selects
   output logic              o_gra,
   output logic              o_grb,
   output logic              o_grc,
   // memory / PC strobes
   output logic              o_read,
   output logic              o_incpc,
   // ALU function and status
   output logic [1:0]        o_alu_op,
   output logic              o_run,
   output logic [3:0]        o_step
);

   // State codes double as the debug step value.
   localparam logic [3:0] S_RST  = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_T4   = 4'd5;
   localparam logic [3:0] S_T5   = 4'd6;
   localparam logic [3:0] S_T6   = 4'd7;
   localparam logic [3:0] S_HALT = 4'd8;

   // Opcodes
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // ALU function codes
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   logic [3:0] r_step;
   logic [3:0] w_step_nxt;

   // Opcode field. It is only meaningful from T3 onward, because IR is
   // loaded at the end of T2; nothing in T0..T2 looks at it.
   logic [4:0] w_op;
   logic       w_is_alu;
   logic       w_is_ldi;
   logic       w_is_br;
   logic       w_is_jr;
   logic       w_is_halt;
   logic [1:0] w_alu_code;

   // Register fields are consumed by the select/encode logic outside this
   // block; only the opcode matters here.
   logic       w_unused_ir;

   // Map a three-operand ALU opcode onto its ALU function code.
   function automatic logic [1:0] f_alu_code(input logic [4:0] op);
      logic [1:0] code;
      code = ALU_ADD;
      case (op)
         OP_ADD:  code = ALU_ADD;
         OP_SUB:  code = ALU_SUB;
         OP_AND:  code = ALU_AND;
         OP_OR:   code = ALU_OR;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

   assign w_op        = i_ir[DATA_W-1 -: 5];
   assign w_unused_ir = ^i_ir[DATA_W-6:0];

   // Opcode class decode. Any opcode not matched here, including the
   // explicit nop, falls through as a nop: nothing is asserted in T3,
   // and T3 returns to T0.
   assign w_is_alu   = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                       (w_op == OP_AND) || (w_op == OP_OR);
   assign w_is_ldi   = (w_op == OP_LDI);
   assign w_is_br    = (w_op == OP_BR);
   assign w_is_jr    = (w_op == OP_JR);
   assign w_is_halt  = (w_op == OP_HALT);
   assign w_alu_code = f_alu_code(w_op);

   // State register: synchronous reset wins over every state, HALT included.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_step <= S_RST;
      end else begin
         r_step <= w_step_nxt;
      end
   end

   // Next-state: fetch is fixed; the length of execute depends on the opcode.
   always_comb begin
      w_step_nxt = r_step;
      case (r_step)
         S_RST:  w_step_nxt = S_T0;
         S_T0:   w_step_nxt = S_T1;
         S_T1:   w_step_nxt = S_T2;
         S_T2:   w_step_nxt = S_T3;
         S_T3: begin
            if (w_is_halt) begin
               w_step_nxt = S_HALT;
            end else if (w_is_alu || w_is_ldi || w_is_br) begin
               w_step_nxt = S_T4;
            end else begin
               w_step_nxt = S_T0;
            end
         end
         S_T4:   w_step_nxt = S_T5;
         S_T5:   w_step_nxt = w_is_br ? S_T6 : S_T0;
         S_T6:   w_step_nxt = S_T0;
         S_HALT: w_step_nxt = S_HALT;
         default: w_step_nxt = S_RST;
      endcase
   end

   // Output decode. Everything defaults low; each state raises only its own
   // strobes, so at most one bus driver is active in any state.
   always_comb begin
      o_pcin   = 1'b0;
      o_mdrin  = 1'b0;
      o_marin  = 1'b0;
      o_irin   = 1'b0;
      o_yin    = 1'b0;
      o_zin    = 1'b0;
      o_conin  = 1'b0;
      o_rin    = 1'b0;
      o_pcout  = 1'b0;
      o_mdrout = 1'b0;
      o_zloout = 1'b0;
      o_cout   = 1'b0;
      o_rout   = 1'b0;
      o_baout  = 1'b0;
      o_gra    = 1'b0;
      o_grb    = 1'b0;
      o_grc    = 1'b0;
      o_read   = 1'b0;
      o_incpc  = 1'b0;
      o_alu_op = ALU_ADD;
      o_run    = 1'b0;
      case (r_step)
         S_T0: begin
            // MAR <- PC, Z <- PC + 1
            o_run   = 1'b1;
            o_pcout = 1'b1;
            o_marin = 1'b1;
            o_incpc = 1'b1;
            o_zin   = 1'b1;
         end
         S_T1: begin
            // PC <- Z, MDR <- M[MAR]
            o_run    = 1'b1;
            o_zloout = 1'b1;
            o_pcin   = 1'b1;
            o_read   = 1'b1;
            o_mdrin  = 1'b1;
         end
         S_T2: begin
            // IR <- MDR
            o_run    = 1'b1;
            o_mdrout = 1'b1;
            o_irin   = 1'b1;
         end
         S_T3: begin
            o_run = 1'b1;
            if (w_is_alu) begin
               // Y <- R[rb]
               o_grb  = 1'b1;
               o_rout = 1'b1;
               o_yin  = 1'b1;
            end else if (w_is_ldi) begin
               // Y <- R[rb], or 0 when rb is R0 (BAout path)
               o_grb   = 1'b1;
               o_baout = 1'b1;
               o_yin   = 1'b1;
            end else if (w_is_br) begin
               // CON <- condition on R[ra]
               o_gra   = 1'b1;
               o_rout  = 1'b1;
               o_conin = 1'b1;
            end else if (w_is_jr) begin
               // PC <- R[ra]
               o_gra  = 1'b1;
               o_rout = 1'b1;
               o_pcin = 1'b1;
            end
         end
         S_T4: begin
            o_run = 1'b1;
            if (w_is_alu) begin
               // Z <- Y op R[rc]
               o_grc    = 1'b1;
               o_rout   = 1'b1;
               o_zin    = 1'b1;
               o_alu_op = w_alu_code;
            end else if (w_is_ldi) begin
               // Z <- Y + C
               o_cout = 1'b1;
               o_zin  = 1'b1;
            end else if (w_is_br) begin
               // Y <- PC
               o_pcout = 1'b1;
               o_yin   = 1'b1;
            end
         end
         S_T5: begin
            o_run = 1'b1;
            if (w_is_alu || w_is_ldi) begin
               // R[ra] <- Z
               o_zloout = 1'b1;
               o_gra    = 1'b1;
               o_rin    = 1'b1;
            end else if (w_is_br) begin
               // Z <- PC + C
               o_cout = 1'b1;
               o_zin  = 1'b1;
            end
         end
         S_T6: begin
            o_run = 1'b1;
            if (w_is_br) begin
               // PC <- Z only when the branch is taken; CON gates the load
               // combinationally so a not-taken branch leaves PC at PC+1.
               o_zloout = 1'b1;
               o_pcin   = i_con;
            end
         end
         default: begin
            // RST and HALT: everything stays low with Run low
         end
      endcase
   end

   assign o_step = r_step;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: drives whole instructions, randomizes IR
// during fetch and CON on every cycle, and checks each cycle against a
// microprogram table that describes every instruction as a list of T-steps.

module tb_control_sequencer;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [31:0] i_ir;
   logic        i_con;
   logic o_pcin, o_mdrin, o_marin, o_irin, o_yin, o_zin, o_conin, o_rin;
   logic o_pcout, o_mdrout, o_zloout, o_cout, o_rout, o_baout;
   logic o_gra, o_grb, o_grc, o_read, o_incpc, o_run;
   logic [1:0] o_alu_op;
   logic [3:0] o_step;

   int n_checks = 0;
   int n_fail   = 0;

   // Bit positions of each strobe within a 21-bit control word
   localparam logic [20:0] PCIN   = 21'(1) << 20;
   localparam logic [20:0] MDRIN  = 21'(1) << 19;
   localparam logic [20:0] MARIN  = 21'(1) << 18;
   localparam logic [20:0] IRIN   = 21'(1) << 17;
   localparam logic [20:0] YIN    = 21'(1) << 16;
   localparam logic [20:0] ZIN    = 21'(1) << 15;
   localparam logic [20:0] CONIN  = 21'(1) << 14;
   localparam logic [20:0] RIN    = 21'(1) << 13;
   localparam logic [20:0] PCOUT  = 21'(1) << 12;
   localparam logic [20:0] MDROUT = 21'(1) << 11;
   localparam logic [20:0] ZLOOUT = 21'(1) << 10;
   localparam logic [20:0] COUT   = 21'(1) << 9;
   localparam logic [20:0] ROUT   = 21'(1) << 8;
   localparam logic [20:0] BAOUT  = 21'(1) << 7;
   localparam logic [20:0] GRA    = 21'(1) << 6;
   localparam logic [20:0] GRB    = 21'(1) << 5;
   localparam logic [20:0] GRC    = 21'(1) << 4;
   localparam logic [20:0] READ   = 21'(1) << 3;
   localparam logic [20:0] INCPC  = 21'(1) << 2;

   logic [20:0] w_obs;
   assign w_obs = {o_pcin, o_mdrin, o_marin, o_irin, o_yin, o_zin, o_conin, o_rin,
                   o_pcout, o_mdrout, o_zloout, o_cout, o_rout, o_baout,
                   o_gra, o_grb, o_grc, o_read, o_incpc, o_alu_op};

   control_sequencer #(.DATA_W(32)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_ir(i_ir), .i_con(i_con),
      .o_pcin(o_pcin), .o_mdrin(o_mdrin), .o_marin(o_marin), .o_irin(o_irin),
      .o_yin(o_yin), .o_zin(o_zin), .o_conin(o_conin), .o_rin(o_rin),
      .o_pcout(o_pcout), .o_mdrout(o_mdrout), .o_zloout(o_zloout),
      .o_cout(o_cout), .o_rout(o_rout), .o_baout(o_baout),
      .o_gra(o_gra), .o_grb(o_grb), .o_grc(o_grc),
      .o_read(o_read), .o_incpc(o_incpc), .o_alu_op(o_alu_op),
      .o_run(o_run), .o_step(o_step)
   );

   always #5 i_clk = ~i_clk;

   // Total clocks from T0 back to T0 for an opcode
   function automatic int instr_len(input logic [4:0] op);
      case (op)
         5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110: return 6;
         5'b10010: return 7;
         default:  return 4;   // jr, nop, halt, unknown
      endcase
   endfunction

   // Microprogram: the control word an instruction asserts in its t-th step
   function automatic logic [20:0] exp_word(input logic [4:0] op, input int t,
                                            input logic con);
      logic [20:0] w;
      logic [1:0]  alu;
      w = '0;
      alu = 2'b00;
      if (op == 5'b00100) alu = 2'b01;
      if (op == 5'b00101) alu = 2'b10;
      if (op == 5'b00110) alu = 2'b11;
      if (t == 0) w = PCOUT | MARIN | INCPC | ZIN;
      else if (t == 1) w = ZLOOUT | PCIN | READ | MDRIN;
      else if (t == 2) w = MDROUT | IRIN;
      else begin
         case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
               if (t == 3) w = GRB | ROUT | YIN;
               if (t == 4) w = GRC | ROUT | ZIN | {19'd0, alu};
               if (t == 5) w = ZLOOUT | GRA | RIN;
            end
            5'b00001: begin
               if (t == 3) w = GRB | BAOUT | YIN;
               if (t == 4) w = COUT | ZIN;
               if (t == 5) w = ZLOOUT | GRA | RIN;
            end
            5'b10010: begin
               if (t == 3) w = GRA | ROUT | CONIN;
               if (t == 4) w = PCOUT | YIN;
               if (t == 5) w = COUT | ZIN;
               if (t == 6) w = ZLOOUT | (con ? PCIN : 21'd0);
            end
            5'b10100: begin
               if (t == 3) w = GRA | ROUT | PCIN;
            end
            default: w = '0;
         endcase
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Hold reset for n edges checking RST each cycle, then drop it so the
   // next edge lands in T0. Returns just after that edge.
   task automatic do_reset(input int n);
      i_reset = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(posedge i_clk); #1;
         i_ir  = $urandom;
         i_con = 1'($urandom);
         @(negedge i_clk);
         chk("rst_step", 32'(o_step), 32'd0);
         chk("rst_run",  32'(o_run),  32'd0);
         chk("rst_word", 32'(w_obs),  32'd0);
      end
      i_reset = 1'b0;
      @(posedge i_clk); #1;
   endtask

   // Run one instruction starting in T0. IR holds junk during fetch.
   // con6 < 0 randomizes CON in T6. rst_at >= 0 asserts reset after that step.
   task automatic run_instr(input logic [31:0] ir, input int rst_at, input int con6);
      int len;
      len = instr_len(ir[31:27]);
      for (int t = 0; t < len; t++) begin
         i_ir    = (t < 3) ? $urandom : ir;
         i_con   = (t == 6 && con6 >= 0) ? con6[0] : 1'($urandom);
         i_reset = 1'b0;
         @(negedge i_clk);
         chk($sformatf("op%05b_t%0d_step", ir[31:27], t), 32'(o_step), 32'(t + 1));
         chk($sformatf("op%05b_t%0d_run", ir[31:27], t), 32'(o_run), 32'd1);
         chk($sformatf("op%05b_t%0d_word", ir[31:27], t), 32'(w_obs),
             32'(exp_word(ir[31:27], t, i_con)));
         chk($sformatf("op%05b_t%0d_bus1", ir[31:27], t),
             32'($countones(w_obs[12:7]) <= 1), 32'd1);
         if (t == rst_at) begin
            do_reset(1);
            return;
         end
         @(posedge i_clk); #1;
      end
   endtask

   initial begin
      logic [4:0]  op;
      logic [31:0] ir_sub;
      i_reset = 1'b1;
      i_ir    = '0;
      i_con   = 1'b0;

      do_reset(3);

      // Fetch sequence via a nop, then branch taken / not taken
      run_instr({5'b11010, 27'($urandom)}, -1, -1);
      run_instr(32'h93180019, -1, 1);
      run_instr(32'h93180019, -1, 0);

      // sub R2, R3, R4
      ir_sub = {5'b00100, 4'd2, 4'd3, 4'd4, 15'd0};
      run_instr(ir_sub, -1, -1);

      // ldi then jr back-to-back
      run_instr({5'b00001, 27'($urandom)}, -1, -1);
      run_instr({5'b10100, 27'($urandom)}, -1, -1);

      // Unknown opcode behaves as nop
      run_instr({5'b11111, 27'($urandom)}, -1, -1);

      // Reset in T4 of an add, then normal restart
      run_instr({5'b00011, 27'($urandom)}, 4, -1);
      run_instr({5'b00110, 27'($urandom)}, -1, -1);

      // Random instruction stream (halt excluded, handled below)
      for (int n = 0; n < 40; n++) begin
         op = 5'($urandom);
         case ($urandom_range(0, 3))
            0: op = 5'b10010;
            1: op = 5'($urandom_range(3, 6));
            default: ;
         endcase
         if (op == 5'b11011) op = 5'b00001;
         run_instr({op, 27'($urandom)}, -1, -1);
      end

      // halt: HALT stays quiet for 20 clocks, then reset restarts
      run_instr({5'b11011, 27'($urandom)}, -1, -1);
      for (int k = 0; k < 20; k++) begin
         i_ir  = $urandom;
         i_con = 1'($urandom);
         @(negedge i_clk);
         chk("halt_step", 32'(o_step), 32'd8);
         chk("halt_run",  32'(o_run),  32'd0);
         chk("halt_word", 32'(w_obs),  32'd0);
         @(posedge i_clk); #1;
      end
      do_reset(2);
      run_instr({5'b11010, 27'($urandom)}, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
